cache_fill_arbiter: RTL

//  Owns the single main-memory port shared by the I-cache and the D-cache.

---
 rtl/cache_fill_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: owns the shared memory port, serving
// I/D line fills and D-cache write-through stores.
module cache_fill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ic_miss,
  input  logic [ADDR_W-1:0]             ic_miss_addr,
  input  logic                          dc_miss,
  input  logic [ADDR_W-1:0]             dc_miss_addr,
  input  logic                          dc_wr,
  input  logic [ADDR_W-1:0]             dc_wr_addr,
  input  logic [DATA_W-1:0]             dc_wr_data,
  output logic                          dc_wr_ack,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          fill_sel,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          fill_tag_we,
  output logic                          busy
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(LINE_WORDS * 2 - 1);
  localparam logic [WB:0] ONE_I = (WB+1)'(1);
  localparam logic [WB-1:0] ONE_R = WB'(1);

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    FILL,
    DONE
  } state_t;

  state_t state;
  logic lastGrant;
  logic [WB:0] issueCnt;
  logic [WB-1:0] rcvCnt;
  logic [ADDR_W-1:0] baseAddr;
  logic pickD;
  logic anyMiss;
  logic [ADDR_W-1:0] missAddr;
  logic [ADDR_W-1:0] alignedBase;

  // pick the fill side: alternate on contention, else the lone miss
  always_comb begin
    pickD = dc_miss;
    if (dc_miss && ic_miss) pickD = ~lastGrant;
    anyMiss = dc_miss | ic_miss;
    missAddr = pickD ? dc_miss_addr : ic_miss_addr;
    alignedBase = missAddr & ~OFF_MASK;
  end

  assign fill_we = (state == FILL) && mem_rvalid;
  assign fill_word = rcvCnt;
  assign fill_data = mem_rdata;
  assign busy = (state != IDLE);

  // grant, issue word reads, count returns, registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lastGrant <= 1'b1;
      issueCnt <= '0;
      rcvCnt <= '0;
      baseAddr <= '0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      dc_wr_ack <= 1'b0;
      fill_sel <= 1'b0;
      fill_tag_we <= 1'b0;
    end else begin
      dc_wr_ack <= 1'b0;
      fill_tag_we <= 1'b0;
      unique case (state)
        IDLE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
          unique case (1'b1)
            dc_wr: begin
              state <= STORE;
              mem_en <= 1'b1;
              mem_wr <= 1'b1;
              mem_addr <= dc_wr_addr;
              mem_wdata <= dc_wr_data;
              dc_wr_ack <= 1'b1;
            end
            (!dc_wr && anyMiss): begin
              state <= FILL;
              lastGrant <= pickD;
              fill_sel <= pickD;
              baseAddr <= alignedBase;
              mem_en <= 1'b1;
              mem_addr <= alignedBase;
              issueCnt <= ONE_I;
              rcvCnt <= '0;
            end
            default: ;
          endcase
        end
        STORE: begin
          state <= IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
        end
        FILL: begin
          if (!issueCnt[WB]) begin
            mem_en <= 1'b1;
            mem_addr <= baseAddr +
              ADDR_W'({issueCnt[WB-1:0], 1'b0});
            issueCnt <= issueCnt + ONE_I;
          end else begin
            mem_en <= 1'b0;
            mem_addr <= '0;
          end
          if (mem_rvalid) begin
            rcvCnt <= rcvCnt + ONE_R;
            if (&rcvCnt) begin
              state <= DONE;
              fill_tag_we <= 1'b1;
              mem_en <= 1'b0;
              mem_addr <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          issueCnt <= '0;
          mem_en <= 1'b0;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
